// File: rtl/shift_sequencer_if.sv
// shift_sequencer_if
//   Groups the request and result handshakes of shift_sequencer.
//
//   Handshake rule: a transfer happens on a rising edge where valid and
//   ready are both 1. The producer holds valid and its payload steady
//   until that edge. Ready may depend combinationally on the other
//   side's signals. Valid never depends combinationally on ready.
//
//   Request side : in_valid, in_ready, in_data[15:0], in_cnt[3:0], in_op[1:0]
//   Result side  : out_valid, out_ready, out_data[15:0]
//   Status       : busy (high whenever the block is not idle)
//
//   Modports:
//     master - the requester/consumer (for example a testbench)
//     slave  - the shift_sequencer itself
interface shift_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [3:0]  in_cnt;
    logic [1:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        busy;

    modport master (
        output in_valid, in_data, in_cnt, in_op, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, in_cnt, in_op, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/shift_sequencer.sv
// shift_sequencer
//   Multi-cycle 16-bit barrel shifter/rotator. An accepted request is
//   processed in four stages. Stage k moves the working value by 2^k
//   positions when bit k of the captured count is set. The result
//   appears exactly four edges after the accept edge, whatever the
//   count is.
//
//   in_op: 00 rotate left, 01 shift left logical,
//          10 rotate right, 11 shift right logical
//
//   Ports:
//     clk       - single clock, rising edge
//     rst_n     - synchronous active-low reset
//     bus       - request/result handshakes (slave modport)
//     dbg_state - current FSM state (IDLE=0, SHIFT=1, DONE=2)
//     dbg_stage - current stage counter (only meaningful in SHIFT)
module shift_sequencer (
    input  logic                clk,
    input  logic                rst_n,
    shift_sequencer_if.slave    bus,
    output logic [1:0]          dbg_state,
    output logic [1:0]          dbg_stage
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  stage_q, stage_d;
    logic [15:0] work_q,  work_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic [1:0]  op_q,    op_d;
    logic [15:0] res_q,   res_d;

    logic        ready;
    logic        accept;
    logic [15:0] stepped;

    // Move v by 2^k positions according to op.
    function automatic logic [15:0] step_value(
        input logic [15:0] v,
        input logic [1:0]  op,
        input logic [1:0]  k
    );
        logic [4:0] amt;
        logic [4:0] back;
        amt  = 5'd1 << k;
        back = 5'd16 - amt;
        case (op)
            2'b00:   step_value = (v << amt) | (v >> back);
            2'b01:   step_value = v << amt;
            2'b10:   step_value = (v >> amt) | (v << back);
            default: step_value = v >> amt;
        endcase
    endfunction

    // A finished result in DONE frees the input side on the same edge it
    // is retired. Because of this, back-to-back requests run without an
    // idle bubble.
    assign ready  = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
    assign accept = bus.in_valid && ready;

    assign stepped = cnt_q[stage_q] ? step_value(work_q, op_q, stage_q) : work_q;

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        res_d   = res_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SHIFT;
                    stage_d = 2'd0;
                    work_d  = bus.in_data;
                    cnt_d   = bus.in_cnt;
                    op_d    = bus.in_op;
                end
            end
            SHIFT: begin
                work_d  = stepped;
                stage_d = stage_q + 2'd1;
                if (stage_q == 2'd3) begin
                    res_d   = stepped;
                    state_d = DONE;
                    stage_d = 2'd0;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    if (accept) begin
                        state_d = SHIFT;
                        stage_d = 2'd0;
                        work_d  = bus.in_data;
                        cnt_d   = bus.in_cnt;
                        op_d    = bus.in_op;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                stage_d = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            stage_q <= 2'd0;
            work_q  <= 16'h0000;
            cnt_q   <= 4'd0;
            op_q    <= 2'd0;
            res_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            res_q   <= res_d;
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_data  = res_q;
    assign bus.busy      = (state_q != IDLE);

    assign dbg_state = state_q;
    assign dbg_stage = stage_q;

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 Parameters: none; datapath fixed at 16 bits, count fixed at 4 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset.
REQ-004 in_valid  input  1  request present on in_data/in_cnt/in_op.
REQ-005 in_ready  output  1  block can accept a request this cycle.
REQ-006 in_data  input  16  operand to shift/rotate.
REQ-007 in_cnt  input  4  shift amount, 0..15.
REQ-008 in_op  input  2  00 rotate left, 01 shift left logical, 10 rotate right, 11 shift right logical.
REQ-009 out_valid  output  1  result present on out_data.
REQ-010 out_ready  input  1  consumer accepts result this cycle.
REQ-011 out_data  output  16  registered result.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 States SHALL be IDLE, SHIFT, DONE; 2-bit stage counter valid in SHIFT only.
REQ-014 Request SHALL be accepted on an edge where in_valid=1 and in_ready=1; in_data, in_cnt, in_op captured into internal registers; next state SHIFT, stage=0.
REQ-015 in_ready SHALL be combinational: 1 in IDLE, 1 in DONE when out_ready=1, 0 otherwise.
REQ-016 In SHIFT, each edge SHALL apply stage k = stage counter: if captured cnt[k]=1, move working value by 2^k per captured op; else hold; then increment stage.
REQ-017 Rotations SHALL wrap bits end-around; logical shifts SHALL fill vacated bits with 0.
REQ-018 Right rotate by n SHALL equal left rotate by 16-n for every n in 1..15.
REQ-019 Edge on which stage=3 is applied SHALL load out_data and enter DONE; result valid exactly 4 edges after the accept edge, independent of count value.
REQ-020 in_cnt=0 SHALL still take 4 SHIFT cycles and return out_data = captured in_data.
REQ-021 In DONE, out_valid=1 and out_data SHALL remain stable until an edge with out_ready=1.
REQ-022 DONE with out_ready=1 and in_valid=0: next state IDLE, out_valid falls.
REQ-023 DONE with out_ready=1 and in_valid=1 (simultaneous complete/accept): result retired and new request captured on same edge; next state SHIFT, stage=0.
REQ-024 in_valid while in_ready=0 SHALL be ignored; no capture, no state change; requester must hold request.
REQ-025 in_data/in_cnt/in_op changes after the accept edge SHALL not affect the result in flight.
REQ-026 out_valid SHALL be registered (state==DONE); no combinational path from in_valid to out_valid.
REQ-027 out_data SHALL retain last result after leaving DONE until next result load.

Reset
REQ-028 On edge with rst_n=0: state IDLE, stage 0, out_valid 0, out_data 16'h0000, busy 0, internal operand registers 0.
REQ-029 Reset SHALL win over all other inputs, including in SHIFT or DONE; in-flight request is discarded with no out_valid pulse.
REQ-030 First edge with rst_n=1 after reset SHALL be able to accept a request (in_ready=1 while rst_n=1 in IDLE).

Verification
REQ-031 rol 16'h1234 cnt 8, out_ready=1 -> out_valid high 4 edges after accept, out_data 16'h3412, then IDLE.
REQ-032 sll 16'h8001 cnt 1 -> 16'h0002; srl 16'h8000 cnt 15 -> 16'h0001; ror 16'h0001 cnt 15 -> 16'h0002; rol 16'hABCD cnt 0 -> 16'hABCD.
REQ-033 Backpressure: out_ready=0 for 3 cycles in DONE with in_valid=1, in_data changing -> out_data constant, in_ready=0, no capture; out_ready=1 -> retire and capture same edge.
REQ-034 Back-to-back: two requests, second held valid -> second accepted on first's retire edge, second result 4 edges later, no bubble cycle in IDLE.
REQ-035 Reset mid-op: rst_n=0 on edge at stage=2 -> next cycle IDLE, out_valid 0, out_data 16'h0000, busy 0; no stale result ever appears.
REQ-036 Exhaustive sweep: all 4 ops x all 16 counts x random in_data checked against reference model; zero mismatches.
